// File: rtl/br_amba_apb_initiator.sv
// APB4 requester: converts a valid/ready command into a single APB transfer
// and returns the completion on a valid/ready response channel. Only one
// transfer is outstanding at a time. An optional ACCESS-phase watchdog ends
// transfers to targets that never raise pready.
//
// Handshake rule (both channels): a beat transfers on a rising clk edge where
// valid && ready. Once rsp_valid is raised, it and all rsp_* fields hold
// until that edge. cmd_ready depends only on the FSM state.

package br_amba;
  localparam int ApbProtWidth = 3;
endpackage

module br_amba_apb_initiator #(
  parameter int AddrWidth     = 12,
  parameter int TimeoutCycles = 0
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            cmd_valid,
  output logic                            cmd_ready,
  input  logic [AddrWidth-1:0]            cmd_addr,
  input  logic                            cmd_write,
  input  logic [31:0]                     cmd_wdata,
  input  logic [3:0]                      cmd_wstrb,
  input  logic [br_amba::ApbProtWidth-1:0] cmd_prot,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [31:0]                     rsp_rdata,
  output logic                            rsp_slverr,
  output logic                            rsp_timeout,
  output logic [AddrWidth-1:0]            paddr,
  output logic [br_amba::ApbProtWidth-1:0] pprot,
  output logic [3:0]                      pstrb,
  output logic                            pwrite,
  output logic [31:0]                     pwdata,
  output logic                            psel,
  output logic                            penable,
  input  logic [31:0]                     prdata,
  input  logic                            pready,
  input  logic                            pslverr
);

  localparam int PW = br_amba::ApbProtWidth;
  // Wait counter holds the 1-based ACCESS cycle index; one bit when unused.
  localparam int CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
  localparam logic [CntWidth-1:0] CntMax     = '1;
  localparam logic [CntWidth-1:0] CntOne     = CntWidth'(1);
  localparam logic [CntWidth-1:0] TimeoutVal = CntWidth'(TimeoutCycles);

  if (AddrWidth < 12) begin : g_addr_width_check
    $error("br_amba_apb_initiator: AddrWidth must be >= 12");
  end

  typedef enum logic [1:0] {
    StIdle,
    StSetup,
    StAccess,
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [CntWidth-1:0]   cnt_q, cnt_d;
  logic [AddrWidth-1:0]  paddr_q, paddr_d;
  logic [PW-1:0]         pprot_q, pprot_d;
  logic [3:0]            pstrb_q, pstrb_d;
  logic                  pwrite_q, pwrite_d;
  logic [31:0]           pwdata_q, pwdata_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  rsp_valid_q, rsp_valid_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;
  logic                  rsp_slverr_q, rsp_slverr_d;
  logic                  rsp_timeout_q, rsp_timeout_d;

  // Next-state and next-output decode; every field holds unless its phase updates it.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    paddr_d       = paddr_q;
    pprot_d       = pprot_q;
    pstrb_d       = pstrb_q;
    pwrite_d      = pwrite_q;
    pwdata_d      = pwdata_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_slverr_d  = rsp_slverr_q;
    rsp_timeout_d = rsp_timeout_q;
    unique case (state_q)
      StIdle: begin
        if (cmd_valid) begin
          paddr_d  = cmd_addr;
          pprot_d  = cmd_prot;
          pwrite_d = cmd_write;
          pwdata_d = cmd_wdata;
          // Reads never carry byte strobes on the bus.
          pstrb_d  = cmd_write ? cmd_wstrb : 4'b0000;
          psel_d   = 1'b1;
          cnt_d    = '0;
          state_d  = StSetup;
        end
      end
      StSetup: begin
        penable_d = 1'b1;
        cnt_d     = CntOne;
        state_d   = StAccess;
      end
      StAccess: begin
        // pready has priority so a late but valid completion is never lost.
        if (pready) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = pwrite_q ? 32'h0 : prdata;
          rsp_slverr_d  = pslverr;
          rsp_timeout_d = 1'b0;
          rsp_valid_d   = 1'b1;
          state_d       = StResp;
        end else if ((TimeoutCycles > 0) && (cnt_q == TimeoutVal)) begin
          psel_d        = 1'b0;
          penable_d     = 1'b0;
          rsp_rdata_d   = 32'h0;
          rsp_slverr_d  = 1'b1;
          rsp_timeout_d = 1'b1;
          rsp_valid_d   = 1'b1;
          state_d       = StResp;
        end else if (cnt_q != CntMax) begin
          cnt_d = cnt_q + CntOne;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM state and all registered outputs; async reset drops the bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      cnt_q         <= '0;
      paddr_q       <= '0;
      pprot_q       <= '0;
      pstrb_q       <= '0;
      pwrite_q      <= 1'b0;
      pwdata_q      <= '0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_slverr_q  <= 1'b0;
      rsp_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      paddr_q       <= paddr_d;
      pprot_q       <= pprot_d;
      pstrb_q       <= pstrb_d;
      pwrite_q      <= pwrite_d;
      pwdata_q      <= pwdata_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_slverr_q  <= rsp_slverr_d;
      rsp_timeout_q <= rsp_timeout_d;
    end
  end

  assign cmd_ready   = (state_q == StIdle);
  assign paddr       = paddr_q;
  assign pprot       = pprot_q;
  assign pstrb       = pstrb_q;
  assign pwrite      = pwrite_q;
  assign pwdata      = pwdata_q;
  assign psel        = psel_q;
  assign penable     = penable_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign rsp_slverr  = rsp_slverr_q;
  assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_br_amba_apb_initiator.sv
// Bench for br_amba_apb_initiator: directed transactions from the test plan
// followed by randomized ones. Each transaction is described by its command,
// the target's wait count and the response backpressure; the expected bus
// and response waveform is derived from that description as a timeline.
module tb_br_amba_apb_initiator;
  localparam int AW   = 12;
  localparam int TO   = 4;
  localparam int PW   = br_amba::ApbProtWidth;
  localparam int NDIR = 11;
  localparam int NTXN = NDIR + 40;
  localparam int MAX_CYC = 20000;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid, cmd_ready, cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0] cmd_wstrb;
  logic [PW-1:0] cmd_prot;
  logic rsp_valid, rsp_ready, rsp_slverr, rsp_timeout;
  logic [31:0] rsp_rdata;
  logic [AW-1:0] paddr;
  logic [PW-1:0] pprot;
  logic [3:0] pstrb;
  logic pwrite, psel, penable, pready, pslverr;
  logic [31:0] pwdata, prdata;

  br_amba_apb_initiator #(.AddrWidth(AW), .TimeoutCycles(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_write(cmd_write), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .cmd_prot(cmd_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
    .paddr(paddr), .pprot(pprot), .pstrb(pstrb), .pwrite(pwrite),
    .pwdata(pwdata), .psel(psel), .penable(penable),
    .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- transaction descriptions ----------------
  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [31:0]   wdata;
    logic [3:0]    wstrb;
    logic [PW-1:0] prot;
    logic [31:0]   prdata;
    logic          err;
    int            w;       // ACCESS cycles with pready low before it rises
    int            delay;   // response cycles with rsp_ready low
    int            gap;     // idle cycles before the command is presented
    int            rst_at;  // timeline step at which reset is pulsed (0 = never)
  } txn_t;

  txn_t tx[NTXN];

  // Observations per transaction, checked against hand-computed literals.
  int acc_cyc[NTXN], rsp_first[NTXN], psel_n[NTXN], pen_n[NTXN], rv_n[NTXN];
  logic [31:0] rd_seen[NTXN];
  logic slv_seen[NTXN], to_seen[NTXN];

  int n_checks = 0;
  int n_fail = 0;
  int cyc = 0;

  // ---------------- scoreboard compare ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic set_dir(input int i, input logic [AW-1:0] addr, input logic write,
                         input logic [31:0] wdata, input logic [3:0] wstrb,
                         input logic [31:0] rdata, input logic err, input int w,
                         input int delay, input int gap, input int rst_at);
    tx[i].addr = addr;   tx[i].write = write; tx[i].wdata = wdata;
    tx[i].wstrb = wstrb; tx[i].prot = PW'($urandom_range(0, 7));
    tx[i].prdata = rdata; tx[i].err = err; tx[i].w = w;
    tx[i].delay = delay; tx[i].gap = gap; tx[i].rst_at = rst_at;
  endtask

  // ---------------- stimulus, model and compare ----------------
  initial begin
    bit busy, in_setup, in_access, in_resp, present;
    int cur, done_cnt, t, n, k, idle_cnt;
    bit tmo;
    logic [AW-1:0] last_addr;
    logic [PW-1:0] last_prot;
    logic [3:0] last_strb;
    logic last_write;
    logic [31:0] last_wdata;

    // Directed plan.
    set_dir(0,  12'h124, 1'b0, 32'h0,        4'hF, 32'hDEADBEEF, 1'b0, 0,   0, 1, 0);
    set_dir(1,  12'hFFC, 1'b1, 32'h12345678, 4'h5, 32'hCAFEF00D, 1'b1, 3,   0, 0, 0);
    set_dir(2,  12'h300, 1'b0, 32'h0,        4'h3, 32'hA5A50001, 1'b0, 1,   4, 0, 0);
    set_dir(3,  12'h040, 1'b0, 32'h0,        4'h0, 32'h11111111, 1'b0, 100, 0, 1, 0);
    set_dir(4,  12'h044, 1'b1, 32'h89ABCDEF, 4'hF, 32'h22222222, 1'b0, 3,   0, 0, 0);
    set_dir(5,  12'h100, 1'b0, 32'h0,        4'hC, 32'h00000005, 1'b0, 0,   0, 0, 0);
    set_dir(6,  12'h104, 1'b1, 32'h66666666, 4'h9, 32'h00000006, 1'b1, 0,   0, 0, 0);
    set_dir(7,  12'h108, 1'b0, 32'h0,        4'h1, 32'h00000007, 1'b0, 0,   0, 0, 0);
    set_dir(8,  12'h200, 1'b0, 32'h0,        4'h0, 32'h88888888, 1'b0, 3,   0, 1, 3);
    set_dir(9,  12'h204, 1'b1, 32'h99999999, 4'h6, 32'h0,        1'b0, 0,   5, 1, 4);
    set_dir(10, 12'h800, 1'b0, 32'h0,        4'h0, 32'hBEEF0010, 1'b0, 2,   0, 1, 0);
    // Random plan: waits up to 6 so some exceed the 4-cycle watchdog.
    for (int i = NDIR; i < NTXN; i++)
      set_dir(i, AW'($urandom), 1'($urandom), $urandom, 4'($urandom), $urandom,
              1'($urandom), $urandom_range(0, 6), $urandom_range(0, 3),
              $urandom_range(0, 2), 0);
    for (int i = 0; i < NTXN; i++) begin
      acc_cyc[i] = 0; rsp_first[i] = 0; psel_n[i] = 0; pen_n[i] = 0; rv_n[i] = 0;
      rd_seen[i] = '0; slv_seen[i] = 1'b0; to_seen[i] = 1'b0;
    end

    // Clock/reset: everything quiet, check reset values while rst_n is low.
    cmd_valid = 1'b0; cmd_addr = '0; cmd_write = 1'b0; cmd_wdata = '0;
    cmd_wstrb = '0; cmd_prot = '0; rsp_ready = 1'b0;
    prdata = '0; pready = 1'b0; pslverr = 1'b0;
    @(negedge clk);
    chk("rst_psel", 32'(psel), 0);        chk("rst_penable", 32'(penable), 0);
    chk("rst_paddr", 32'(paddr), 0);      chk("rst_pprot", 32'(pprot), 0);
    chk("rst_pstrb", 32'(pstrb), 0);      chk("rst_pwrite", 32'(pwrite), 0);
    chk("rst_pwdata", pwdata, 0);         chk("rst_rsp_valid", 32'(rsp_valid), 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);   chk("rst_rsp_slverr", 32'(rsp_slverr), 0);
    chk("rst_rsp_timeout", 32'(rsp_timeout), 0);
    chk("rst_cmd_ready", 32'(cmd_ready), 1);
    @(negedge clk);
    rst_n = 1'b1;

    busy = 1'b0; cur = 0; done_cnt = 0; t = 0; n = 0; tmo = 1'b0; idle_cnt = 0;
    last_addr = '0; last_prot = '0; last_strb = '0; last_write = 1'b0; last_wdata = '0;

    while (done_cnt < NTXN && cyc < MAX_CYC) begin
      // ---- compare this cycle's outputs against the timeline ----
      in_setup  = busy && (t == 1);
      in_access = busy && (t >= 2) && (t <= n + 1);
      in_resp   = busy && (t >= n + 2);
      chk("cmd_ready", 32'(cmd_ready), 32'(!busy));
      chk("psel", 32'(psel), 32'(in_setup || in_access));
      chk("penable", 32'(penable), 32'(in_access));
      chk("rsp_valid", 32'(rsp_valid), 32'(in_resp));
      chk("paddr", 32'(paddr), 32'(last_addr));
      chk("pprot", 32'(pprot), 32'(last_prot));
      chk("pstrb", 32'(pstrb), 32'(last_strb));
      chk("pwrite", 32'(pwrite), 32'(last_write));
      chk("pwdata", pwdata, last_wdata);
      if (in_resp) begin
        chk("rsp_rdata", rsp_rdata, (tmo || tx[cur].write) ? 32'h0 : tx[cur].prdata);
        chk("rsp_slverr", 32'(rsp_slverr), 32'(tmo ? 1'b1 : tx[cur].err));
        chk("rsp_timeout", 32'(rsp_timeout), 32'(tmo));
      end
      if (busy) begin
        psel_n[cur] += int'(psel);
        pen_n[cur]  += int'(penable);
        if (rsp_valid && rv_n[cur] == 0) begin
          rsp_first[cur] = cyc; rd_seen[cur] = rsp_rdata;
          slv_seen[cur] = rsp_slverr; to_seen[cur] = rsp_timeout;
        end
        rv_n[cur] += int'(rsp_valid);
      end

      // ---- reset pulse in the middle of a cycle ----
      if (busy && tx[cur].rst_at == t) begin
        cmd_valid = 1'b0; rsp_ready = 1'b0; pready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst_psel", 32'(psel), 0);
        chk("async_rst_penable", 32'(penable), 0);
        chk("async_rst_rsp_valid", 32'(rsp_valid), 0);
        chk("async_rst_cmd_ready", 32'(cmd_ready), 1);
        busy = 1'b0; done_cnt++; cur++; idle_cnt = 0;
        last_addr = '0; last_prot = '0; last_strb = '0; last_write = 1'b0; last_wdata = '0;
        @(negedge clk);
        cyc++;
        rst_n = 1'b1;
        continue;
      end

      // ---- drive inputs for the coming edge ----
      k = t - 1;
      if (in_access) begin
        pready  = (k == tx[cur].w + 1);
        prdata  = pready ? tx[cur].prdata : $urandom;
        pslverr = pready ? tx[cur].err : 1'($urandom);
      end else begin
        // Outside ACCESS the target lines carry junk that must be ignored.
        pready = 1'($urandom); prdata = $urandom; pslverr = 1'($urandom);
      end
      rsp_ready = in_resp ? ((t - (n + 2)) >= tx[cur].delay) : 1'($urandom);
      present = 1'b0;
      if (!busy) begin
        if (cur < NTXN && idle_cnt >= tx[cur].gap) begin
          present = 1'b1;
          cmd_valid = 1'b1; cmd_addr = tx[cur].addr; cmd_write = tx[cur].write;
          cmd_wdata = tx[cur].wdata; cmd_wstrb = tx[cur].wstrb; cmd_prot = tx[cur].prot;
        end else begin
          cmd_valid = 1'b0;
        end
      end else begin
        // While busy, commands may wiggle freely and must not be taken.
        cmd_valid = 1'($urandom); cmd_addr = AW'($urandom); cmd_write = 1'($urandom);
        cmd_wdata = $urandom; cmd_wstrb = 4'($urandom); cmd_prot = PW'($urandom);
      end

      @(posedge clk);
      // ---- advance the timeline past this edge ----
      if (!busy) begin
        if (present) begin
          acc_cyc[cur] = cyc;
          busy = 1'b1; t = 1;
          tmo = (tx[cur].w >= TO);
          n = tmo ? TO : tx[cur].w + 1;
          last_addr = tx[cur].addr; last_prot = tx[cur].prot; last_write = tx[cur].write;
          last_wdata = tx[cur].wdata; last_strb = tx[cur].write ? tx[cur].wstrb : 4'h0;
        end else begin
          idle_cnt++;
        end
      end else if (in_resp && rsp_ready) begin
        busy = 1'b0; done_cnt++; cur++; idle_cnt = 0;
      end else begin
        t++;
      end
      cyc++;
      @(negedge clk);
    end

    if (done_cnt < NTXN) begin
      n_checks++; n_fail++;
      $display("FAIL cycle_budget: completed %0d of %0d transactions", done_cnt, NTXN);
    end

    // Hand-computed literal expectations for the directed plan.
    chk("read0_latency", 32'(rsp_first[0] - acc_cyc[0]), 3);
    chk("read0_rdata", rd_seen[0], 32'hDEADBEEF);
    chk("read0_psel_cycles", 32'(psel_n[0]), 2);
    chk("read0_penable_cycles", 32'(pen_n[0]), 1);
    chk("write1_psel_cycles", 32'(psel_n[1]), 5);
    chk("write1_slverr", 32'(slv_seen[1]), 1);
    chk("write1_rdata", rd_seen[1], 32'h0);
    chk("bp2_rsp_valid_cycles", 32'(rv_n[2]), 5);
    chk("wd3_psel_cycles", 32'(psel_n[3]), 5);
    chk("wd3_penable_cycles", 32'(pen_n[3]), 4);
    chk("wd3_timeout", 32'(to_seen[3]), 1);
    chk("wd3_slverr", 32'(slv_seen[3]), 1);
    chk("late4_timeout", 32'(to_seen[4]), 0);
    chk("late4_psel_cycles", 32'(psel_n[4]), 5);
    chk("b2b_spacing_5_6", 32'(acc_cyc[6] - acc_cyc[5]), 4);
    chk("b2b_spacing_6_7", 32'(acc_cyc[7] - acc_cyc[6]), 4);
    chk("post_reset10_rdata", rd_seen[10], 32'hBEEF0010);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/br_amba_apb_initiator.md
Name: br_amba_apb_initiator

Overview:
APB4 requester (initiator) that turns a valid/ready command channel into single APB transfers and returns each completion on a valid/ready response channel. It sits at the host side of an APB segment and drives targets directly or through APB timing slices. It issues one outstanding transfer at a time. An optional access-phase watchdog terminates transfers to hung targets.

Parameters:
AddrWidth, 12, APB address width; must be >= 12 (static assertion).
TimeoutCycles, 0, maximum ACCESS-phase cycles without pready before forced termination; 0 disables the watchdog.

Ports:
clk  input  1  clock
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command valid
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_addr  input  AddrWidth  transfer address
cmd_write  input  1  1 = write, 0 = read
cmd_wdata  input  32  write data
cmd_wstrb  input  4  write byte strobes
cmd_prot  input  br_amba::ApbProtWidth  protection attributes
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  32  read data; 0 for writes and timeouts
rsp_slverr  output  1  pslverr captured, or 1 on timeout
rsp_timeout  output  1  response was produced by the watchdog
paddr, pprot, pstrb, pwrite, pwdata  output  AddrWidth/ApbProtWidth/4/1/32  APB request fields
psel, penable  output  1  APB select/enable
prdata  input  32  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Clock and reset: single clock clk. rst_n is asynchronous and active-low. While rst_n is low, state=IDLE and all registered outputs are 0 (psel, penable, paddr, pprot, pstrb, pwrite, pwdata, rsp_valid, rsp_rdata, rsp_slverr, rsp_timeout).
- Output timing: every APB output and response output is driven from a flop. cmd_ready = (state==IDLE) is decoded from state only, with no combinational path from any input.
- FSM IDLE: cmd_ready=1. On cmd_valid, register all cmd fields into the APB outputs, with pstrb forced to 4'b0 when cmd_write=0, set psel=1, and go to SETUP.
- FSM SETUP: psel=1, penable=0. Unconditionally go to ACCESS and set penable=1.
- FSM ACCESS: psel=1, penable=1. The wait counter holds k, the 1-based index of the current ACCESS cycle.
  - If pready=1: psel=penable=0. Capture rsp_rdata = pwrite ? 0 : prdata, rsp_slverr=pslverr, rsp_timeout=0. Set rsp_valid=1 and go to RESP.
  - Else if TimeoutCycles>0 and k==TimeoutCycles: psel=penable=0, rsp_rdata=0, rsp_slverr=1, rsp_timeout=1, rsp_valid=1. Go to RESP.
  - pready in the same cycle as timeout expiry wins and produces a normal completion.
  - Counter width is $clog2(TimeoutCycles+1), minimum 1 bit. It saturates and never wraps; it clears on entry to SETUP.
- FSM RESP: rsp_valid=1 and response fields stable until rsp_ready. On the handshake, clear rsp_valid and go to IDLE. A new command is accepted no earlier than the cycle after the handshake.
- Field stability: paddr, pprot, pstrb, pwrite and pwdata are stable from SETUP through the end of ACCESS. They then hold their last value until the next accept; they do not return to 0.
- Cycle latency with a zero-wait target: accept at cycle T; SETUP at T+1; ACCESS at T+2 with pready=1; rsp_valid at T+3. If rsp_ready=1 at T+3, cmd_ready=1 at T+4.
- Input tolerance: cmd_* inputs are ignored outside IDLE. pready, prdata and pslverr are ignored outside ACCESS.
- Reset mid-transfer: asserting rst_n low mid-transfer drops psel and penable immediately (asynchronously) and discards any pending response.

Test Plan:
- Zero-wait read: cmd addr=0x124, write=0; pready=1 on the first ACCESS cycle with prdata=0xDEADBEEF -> psel high 2 cycles, penable high 1 cycle, pstrb=0, rsp_valid at T+3 with rdata=0xDEADBEEF, slverr=0.
- Write with wait states and error: addr=0xFFC, wdata=0x12345678, wstrb=4'b0101; pready low for 3 ACCESS cycles, then high with pslverr=1 -> paddr, pwdata and pstrb stable for all 5 psel cycles; rsp rdata=0, slverr=1, timeout=0.
- Response backpressure: rsp_ready held low for 4 cycles after rsp_valid -> rsp fields stable, cmd_ready=0 throughout, a new cmd_valid is not accepted until the cycle after the handshake.
- Watchdog with TimeoutCycles=4: pready never asserted -> exactly 4 ACCESS cycles, then psel=0; rsp slverr=1, timeout=1, rdata=0. In a repeat where pready rises in the 4th ACCESS cycle -> normal completion with timeout=0.
- Back-to-back with rsp_ready tied 1: 3 commands presented continuously -> accepts spaced 4 cycles apart, no psel glitch between transfers, responses returned in order.
- Async reset in ACCESS: rst_n pulled low mid-cycle -> psel, penable and rsp_valid go to 0 before the next clock edge; after release cmd_ready=1 and the next transfer completes normally.
